// File: rtl/lbp_pkg.sv
// Shared widths and FSM encoding for the LBP gray-image responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lbp_pkg;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int IMG_W = 128;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Host writes land in RAM in every state except SERVE.
  function automatic logic accepts_load(input state_e s);
    return (s != ST_SERVE);
  endfunction

endpackage

// File: rtl/gray_ram.sv
// Single-image pixel store: one synchronous write port, one registered read port.
// Latency: read data valid one edge after re_i is sampled high.
// Backpressure: none; rdata_o holds its value while re_i is low.
module gray_ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register clears on reset and holds between reads.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gray_mem_responder.sv
// Gray-image responder: host loads an image, then the LBP engine reads pixels until finish.
// Latency: gray_data valid one edge after gray_req is sampled in SERVE.
// Backpressure: none; one read per cycle, misuse is flagged on the sticky proto_err.
module gray_mem_responder
  import lbp_pkg::*;
#(
  parameter int AW = lbp_pkg::AW,
  parameter int DW = lbp_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  input  logic          finish,
  output logic          gray_ready,
  output logic [DW-1:0] gray_data,
  output logic [AW:0]   served_cnt,
  output logic          proto_err
);

  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  state_e      state_q, state_d;
  logic [AW:0] served_cnt_q, served_cnt_d;
  logic        proto_err_q, proto_err_d;
  logic        in_serve;
  logic        ram_we;
  logic        ram_re;

  assign in_serve = (state_q == ST_SERVE);
  assign ram_we   = load_valid & accepts_load(state_q);
  assign ram_re   = gray_req & in_serve;

  // State register; async reset drops gray_ready immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Next-state: load_last closes an image, finish ends service, any load beat in DONE reopens.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (load_valid && load_last) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (finish) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (load_valid) state_d = load_last ? ST_SERVE : ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Counter clears on any accepted load beat (new image) and saturates at one full image.
  always_comb begin
    served_cnt_d = served_cnt_q;
    if (ram_we)                              served_cnt_d = '0;
    else if (ram_re && served_cnt_q != CNT_MAX) served_cnt_d = served_cnt_q + 1'b1;
  end

  // Sticky error: a load during SERVE or a read outside SERVE.
  always_comb begin
    proto_err_d = proto_err_q;
    if ((load_valid && in_serve) || (gray_req && !in_serve)) proto_err_d = 1'b1;
  end

  // Counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      served_cnt_q <= served_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  gray_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (ram_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (gray_addr),
    .rdata_o (gray_data)
  );

  assign gray_ready = in_serve;
  assign served_cnt = served_cnt_q;
  assign proto_err  = proto_err_q;

endmodule
